// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;

  // An out-of-range latency is pinned to the nearest legal value so the 3-bit counter never wraps.
  function automatic int clamp_lat(input int lat);
    if (lat < MEM_LAT_MIN) return MEM_LAT_MIN;
    if (lat > MEM_LAT_MAX) return MEM_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - core/host arbiter for the single-port data memory
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_halt,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              core_gnt,
  output logic              host_gnt,
  output logic              core_done,
  output logic              host_done,
  output logic [DATA_W-1:0] rdata,
  output logic              dm_en,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam logic [2:0] LAT = 3'(clamp_lat(MEM_LAT));

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win;

  // Halt gives the host absolute priority; otherwise a tie goes to whoever was not granted last.
  function automatic logic pick_winner(input logic c_req, input logic h_req,
                                       input logic halt, input logic last);
    if (c_req && !h_req) return OWN_CORE;
    if (h_req && !c_req) return OWN_HOST;
    if (halt)            return OWN_HOST;
    return (last == OWN_CORE) ? OWN_HOST : OWN_CORE;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    win     = pick_winner(core_req, host_req, core_halt, last_q);
    case (state_q)
      IDLE: begin
        if (core_req || host_req) begin
          owner_d = win;
          last_d  = win;
          we_d    = (win == OWN_HOST) ? host_we    : core_we;
          addr_d  = (win == OWN_HOST) ? host_addr  : core_addr;
          wdata_d = (win == OWN_HOST) ? host_wdata : core_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = LAT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q <= 3'd1) begin
          rdata_d = dm_rdata;
          cnt_d   = 3'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      owner_q <= OWN_CORE;
      last_q  <= OWN_HOST;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Address/data come straight from the latched request, so they hold between accesses.
  assign dm_en     = (state_q == ACCESS);
  assign dm_we     = dm_en && we_q;
  assign dm_addr   = addr_q;
  assign dm_wdata  = wdata_q;
  assign core_gnt  = dm_en && (owner_q == OWN_CORE);
  assign host_gnt  = dm_en && (owner_q == OWN_HOST);
  assign core_done = (state_q == RESP) && (owner_q == OWN_CORE);
  assign host_done = (state_q == RESP) && (owner_q == OWN_HOST);
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter with a latency-accurate memory model
module tb_dm_arbiter;

  localparam int LAT = 3;
  localparam logic CORE = 1'b0;
  localparam logic HOST = 1'b1;

  logic        clock;
  logic        rst;
  logic        core_req, core_we, core_halt;
  logic [15:0] core_addr;
  logic [7:0]  core_wdata;
  logic        host_req, host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        core_gnt, host_gnt, core_done, host_done;
  logic [7:0]  rdata;
  logic        dm_en, dm_we;
  logic [15:0] dm_addr;
  logic [7:0]  dm_wdata;
  logic [7:0]  dm_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  dm_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(LAT)) dut (
    .clock(clock), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_halt(core_halt),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata),
    .core_gnt(core_gnt), .host_gnt(host_gnt),
    .core_done(core_done), .host_done(host_done),
    .rdata(rdata), .dm_en(dm_en), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: unwritten locations read as addr^0x5A; read data is valid only in cycle A+LAT.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  bit   [7:0] mem_arr [256];
  bit         mem_vld [256];
  logic [7:0] pipe    [LAT];

  always @(posedge clock) begin
    if (dm_en && dm_we) begin
      mem_arr[dm_addr[7:0]] <= dm_wdata;
      mem_vld[dm_addr[7:0]] <= 1'b1;
    end
    pipe[0] <= (dm_en && !dm_we) ?
               (mem_vld[dm_addr[7:0]] ? mem_arr[dm_addr[7:0]] : init_val(dm_addr)) : 8'hEE;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign dm_rdata = pipe[LAT-1];

  // Reference model state
  logic       last_own;
  logic [7:0] last_rdata;
  logic [7:0] ref_mem [logic [15:0]];

  function automatic logic [7:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic model_pick(input logic c, input logic h, input logic halt, input logic last);
    if (c && h) return halt ? HOST : ~last;
    return h ? HOST : CORE;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {core_gnt, host_gnt, core_done, host_done, dm_en, dm_we, dm_addr, dm_wdata, rdata}, 64'd0);
  endtask

  // Serve one access from the currently driven inputs; exp_wait = negedges until gnt.
  task automatic serve(input string tag, input int exp_wait);
    logic own, we;
    logic [15:0] a;
    logic [7:0] wd, rd;
    int k;
    bit got;
    own = model_pick(core_req, host_req, core_halt, last_own);
    last_own = own;
    we = (own == HOST) ? host_we    : core_we;
    a  = (own == HOST) ? host_addr  : core_addr;
    wd = (own == HOST) ? host_wdata : core_wdata;
    if (we) begin
      rd = last_rdata;
      ref_mem[a] = wd;
    end else begin
      rd = ref_read(a);
      last_rdata = rd;
    end
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(negedge clock); k++;
      if (core_gnt || host_gnt) got = 1;
    end
    check({tag, "_gnt_wait"}, k, exp_wait);
    check({tag, "_gnt"}, {core_gnt, host_gnt}, (own == HOST) ? 2'b01 : 2'b10);
    check({tag, "_bus"}, {dm_en, dm_we, dm_addr, dm_wdata}, {1'b1, we, a, wd});
    k = 0; got = 0;
    while (!got && k < 20) begin
      @(negedge clock); k++;
      if (core_done || host_done) got = 1;
      else check({tag, "_hold"}, {dm_en, dm_we, core_gnt, host_gnt, dm_addr}, {4'b0000, a});
    end
    check({tag, "_done_lat"}, k, we ? 1 : LAT + 1);
    check({tag, "_done"}, {core_done, host_done}, (own == HOST) ? 2'b01 : 2'b10);
    check({tag, "_rdata"}, rdata, rd);
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic drive_host(input logic req, input logic we, input logic [15:0] a, input logic [7:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; core_halt = 1'b0;
    drive_core(0, 0, 16'h0, 8'h0);
    drive_host(0, 0, 16'h0, 8'h0);
    last_own = HOST; last_rdata = 8'h00;
    repeat (2) @(negedge clock);
    check_all_zero("reset_outputs");
    rst = 1'b1;
    @(negedge clock);
    check_all_zero("idle_after_reset");

    // Core write then host read-back of the same location
    drive_core(1, 1, 16'h0010, 8'hA5);
    serve("core_wr", 1);
    drive_core(0, 0, 16'h0, 8'h0);
    @(negedge clock);
    drive_host(1, 0, 16'h0010, 8'h00);
    serve("host_rd_back", 1);
    check("host_rd_back_val", rdata, 8'hA5);
    drive_host(0, 0, 16'h0, 8'h0);
    @(negedge clock);

    // Host read whose memory word is 0x3C
    drive_host(1, 0, 16'h0066, 8'h00);
    serve("host_rd_3c", 1);
    check("host_rd_3c_val", rdata, 8'h3C);
    drive_host(0, 0, 16'h0, 8'h0);
    @(negedge clock);

    // Round robin with both held
    drive_core(1, 1, 16'h0020, 8'h11);
    drive_host(1, 0, 16'h0010, 8'h00);
    serve("rr0", 1);
    check("rr0_owner", core_done, 1'b1);
    for (int i = 1; i < 4; i++) serve($sformatf("rr%0d", i), 2);
    drive_core(0, 0, 16'h0, 8'h0);
    drive_host(0, 0, 16'h0, 8'h0);
    @(negedge clock);

    // Halt: host wins every tie, then core wins once halt drops
    core_halt = 1'b1;
    drive_core(1, 0, 16'h0020, 8'h00);
    drive_host(1, 1, 16'h0044, 8'h77);
    serve("halt0", 1);
    serve("halt1", 2);
    serve("halt2", 2);
    core_halt = 1'b0;
    serve("unhalt", 2);
    check("unhalt_core", core_done, 1'b1);
    drive_core(0, 0, 16'h0, 8'h0);
    drive_host(0, 0, 16'h0, 8'h0);
    @(negedge clock);

    // Reset in the middle of a core read's WAIT
    drive_core(1, 0, 16'h0030, 8'h00);
    @(negedge clock);
    check("rst_pre_gnt", core_gnt, 1'b1);
    drive_core(0, 0, 16'h0, 8'h0);
    @(negedge clock);
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid_wait");
    last_own = HOST; last_rdata = 8'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst_no_done", {core_done, host_done}, 2'b00);
    end
    rst = 1'b1;
    @(negedge clock);
    check("rst_release_no_done", {core_done, host_done}, 2'b00);
    drive_core(1, 0, 16'h0030, 8'h00);
    serve("after_rst_rd", 1);
    check("after_rst_rd_val", rdata, 8'h6A);

    // Level semantics: req held through done gives a second access after one IDLE cycle
    serve("level_second", 2);
    drive_core(0, 0, 16'h0, 8'h0);
    @(negedge clock);

    // Randomized accesses against the model
    for (int it = 0; it < 40; it++) begin
      logic c, h;
      c = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      if (!c && !h) c = 1'b1;
      core_halt = ($urandom_range(0, 3) == 0);
      drive_core(c, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 8'($urandom));
      drive_host(h, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 8'($urandom));
      serve($sformatf("rnd%0d", it), 1);
      drive_core(0, 0, 16'h0, 8'h0);
      drive_host(0, 0, 16'h0, 8'h0);
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter for the single-port data memory of the matrix-multiplication processor. It shares the memory between the processor core (operand fetch and result store over `ar_out`/`bus_out`) and a host loader port that preloads matrices and reads back results. It serialises accesses, drives the memory enable/address/data lines, waits out the fixed memory read latency and returns read data to the owner with a one-cycle completion pulse. Round-robin fairness applies, with absolute host priority while the core is halted.

## Interface
- `ADDR_W`, 16, address width (matches `ar_out`)
- `DATA_W`, 8, data width (matches `dm_out`)
- `MEM_LAT`, 1, cycles from `dm_en` to valid `dm_rdata`; legal range 1..7

- `clock`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `core_req`, `host_req`  in  1 each  access request; level, held until `*_done`
- `core_we`, `host_we`  in  1 each  1 = write, 0 = read; valid while `*_req`
- `core_addr`, `host_addr`  in  ADDR_W each  access address
- `core_wdata`, `host_wdata`  in  DATA_W each  write data
- `core_halt`  in  1  core finished (`end_process`); host gets priority
- `core_gnt`, `host_gnt`  out  1 each  request accepted; one-cycle pulse
- `core_done`, `host_done`  out  1 each  access complete; one-cycle pulse
- `rdata`  out  DATA_W  read data, valid only with `*_done` of a read
- `dm_en`, `dm_we`  out  1 each  memory enable / write strobe
- `dm_addr`  out  ADDR_W, `dm_wdata`  out  DATA_W  memory address / write data
- `dm_rdata`  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any `*_req` is high at the clock edge, pick a winner, latch its `we`/`addr`/`wdata` and the owner, and go to ACCESS. Otherwise stay.
- Winner selection:
  - only one requester active: that requester wins;
  - both active with `core_halt`=1: host wins;
  - both active with `core_halt`=0: the requester not granted last wins;
  - the last-owner pointer updates on every grant.
- ACCESS (one cycle): `dm_en`=1, `dm_we`=latched `we`, `dm_addr`/`dm_wdata` from the latched values, owner `*_gnt`=1. A write goes to RESP; a read goes to WAIT.
- WAIT: the counter loads `MEM_LAT` on entry and decrements each cycle. On the final WAIT cycle `dm_rdata` is registered into `rdata`, then the FSM goes to RESP.
- RESP (one cycle): owner `*_done`=1; `rdata` holds the captured value for reads and keeps its previous value for writes. Then go to IDLE.
- `*_req` is ignored outside IDLE. A requester drops `req` no later than its `done` cycle; a `req` still high in the following IDLE counts as a new access.
- Outside ACCESS, `dm_en`=`dm_we`=0, and `dm_addr`/`dm_wdata` hold their last values.
- `core_halt` changing mid-access does not affect the current access; it is sampled only in IDLE.

## Timing
- Take ACCESS as cycle A:
  - write: `gnt` and `dm_en` in A, `done` in A+1; 3 cycles per write including IDLE;
  - read: `gnt` in A, `dm_rdata` sampled at end of A+MEM_LAT, `done`+`rdata` in A+MEM_LAT+1.
- A request seen in IDLE at edge E gets `gnt` in the cycle starting at E.
- Back-to-back accesses always have at least one IDLE cycle between RESP and the next ACCESS.
- Reset (asynchronous, active-low, any state, including mid-WAIT):
  - state→IDLE, WAIT counter→0;
  - all outputs→0 (`dm_en`, `dm_we`, `dm_addr`, `dm_wdata`, `rdata`, all `gnt`/`done`);
  - last-owner→host, so the core wins the first tie;
  - an interrupted access produces no `done`.

## Structure
- Shared package `dm_arb_pkg`: state enum (IDLE/ACCESS/WAIT/RESP), owner encoding (`OWN_CORE`=0, `OWN_HOST`=1), and `MEM_LAT` range-check constants.
- Single module. The winner pick is a local function, not a sub-module. The WAIT counter is 3 bits.

## Test plan
- Core write, addr 0x0010, data 0xA5: `core_gnt` and `dm_en`/`dm_we` in A with `dm_addr`=0x0010 and `dm_wdata`=0xA5; `core_done` in A+1; a later host read of 0x0010 returns 0xA5.
- Host read with `MEM_LAT`=3, memory returns 0x3C: `dm_rdata` sampled at end of A+3; `host_done`=1 and `rdata`=0x3C in A+4; `core_done` stays 0.
- Both requesters held high for 4 accesses with `core_halt`=0: grant order core, host, core, host.
- Both high with `core_halt`=1: host wins every time while the core waits; after `core_halt` drops, the core wins the next tie.
- Assert `rst` low during WAIT of a core read: all outputs 0 immediately, no `core_done`; after release, a core re-request is served normally.
- Core keeps `req` high through `done`: a second access is accepted and a second `gnt` appears after one IDLE cycle, confirming level-request semantics.
